// File: rtl/sort4_pkg.sv
// -----------------------------------------------------------------------------
// sort4_pkg
// Shared types for the 4-input sorter and its downstream drain.
//   SORT_W        : default element width in bits
//   elem_t        : one sorted element
//   set_t         : one result set, element 0 (smallest) in index 0
//   drain_state_e : emission FSM states of sort4_drain
// -----------------------------------------------------------------------------
package sort4_pkg;

  localparam int SORT_W = 8;

  typedef logic [SORT_W-1:0] elem_t;
  typedef elem_t [3:0]       set_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } drain_state_e;

endpackage

// File: rtl/sort4_set_fifo.sv
// -----------------------------------------------------------------------------
// sort4_set_fifo
// DEPTH-entry FIFO of result sets (four W-bit elements each).
//   clk, rst   : clock, synchronous active-high reset
//   push       : write wdata; taken when not full, or when full with a pop
//   pop        : discard the head set (ignored when empty)
//   wdata      : set to write, element 0 in index 0
//   head       : set at the read pointer
//   head_next  : set that becomes head after a pop this cycle
//   full/empty : occupancy == DEPTH / occupancy == 0
//   occupancy  : number of stored sets
// -----------------------------------------------------------------------------
module sort4_set_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [3:0][W-1:0]          wdata,
  output logic [3:0][W-1:0]          head,
  output logic [3:0][W-1:0]          head_next,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int OCC_W = PW + 1;

  logic [3:0][W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_inc;
  logic [OCC_W-1:0]  occ_q;
  logic              push_ok, pop_ok;

  assign full       = (occ_q == OCC_W'(DEPTH));
  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;

  // A full buffer still takes a set when the head leaves in the same cycle.
  assign pop_ok     = pop & ~empty;
  assign push_ok    = push & (~full | pop_ok);

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign rd_ptr_inc = rd_ptr_q + PW'(1);
  assign head       = mem_q[rd_ptr_q];
  // With only one set stored, whatever follows it is the set being written now.
  assign head_next  = (occ_q > OCC_W'(1)) ? mem_q[rd_ptr_inc] : wdata;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_inc;
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy and pointers decide what is valid,
  // and leaving it out keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sort4_drain.sv
// -----------------------------------------------------------------------------
// sort4_drain
// Captures sorted result sets from the sorter on `done`, buffers them and
// serialises them smallest-first onto a valid/ready element stream.
//   clk, rst          : clock, synchronous active-high reset
//   done, r0..r3      : sorter completion strobe and sorted elements
//   can_accept        : buffer not full (sorter start allowed)
//   out_valid/ready   : output handshake
//   out_data/idx/last : element, its position in the set, last-element flag
//   overflow          : sticky, a set arrived while full and was dropped
//   order_err         : sticky, a set arrived not non-decreasing
//   sets_out          : count of fully emitted sets (wraps)
// -----------------------------------------------------------------------------
module sort4_drain
  import sort4_pkg::*;
#(
  parameter int W     = SORT_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             done,
  input  logic [W-1:0]     r0,
  input  logic [W-1:0]     r1,
  input  logic [W-1:0]     r2,
  input  logic [W-1:0]     r3,
  output logic             can_accept,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             overflow,
  output logic             order_err,
  output logic [CNT_W-1:0] sets_out
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  drain_state_e      state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [W-1:0]      data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  sets_q, sets_d;
  logic              overflow_q, overflow_d;
  logic              order_err_q, order_err_d;

  logic [3:0][W-1:0] wdata, head, head_next;
  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  occupancy;
  logic              transfer, pop, more_sets, set_unordered;

  assign wdata = {r3, r2, r1, r0};

  sort4_set_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (done),
    .pop       (pop),
    .wdata     (wdata),
    .head      (head),
    .head_next (head_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  assign can_accept    = ~fifo_full;
  assign transfer      = (state_q == EMIT) & out_ready;
  // After popping the head another set remains if one was already queued
  // behind it, or one arrives now (a push alongside a pop is always taken).
  assign more_sets     = (occupancy > OCC_W'(1)) | done;
  assign set_unordered = ~((r0 <= r1) && (r1 <= r2) && (r2 <= r3));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    sets_d  = sets_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = EMIT;
          idx_d   = 2'd0;
          data_d  = head[0];
          last_d  = 1'b0;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (idx_q != 2'd3) begin
            idx_d  = idx_q + 2'd1;
            data_d = head[idx_d];
            last_d = (idx_d == 2'd3);
          end else begin
            pop    = 1'b1;
            sets_d = sets_q + CNT_W'(1);
            idx_d  = 2'd0;
            last_d = 1'b0;
            // Preload the next set's first element so there is no bubble.
            if (more_sets) begin
              data_d = head_next[0];
            end else begin
              state_d = IDLE;
              data_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropped sets are checked for order as well as stored ones.
    overflow_d  = overflow_q  | (done & fifo_full & ~pop);
    order_err_d = order_err_q | (done & set_unordered);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      data_q      <= '0;
      last_q      <= 1'b0;
      sets_q      <= '0;
      overflow_q  <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      last_q      <= last_d;
      sets_q      <= sets_d;
      overflow_q  <= overflow_d;
      order_err_q <= order_err_d;
    end
  end

  assign out_valid = (state_q == EMIT);
  assign out_data  = data_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign overflow  = overflow_q;
  assign order_err = order_err_q;
  assign sets_out  = sets_q;

endmodule

// File: tb/tb_sort4_drain.sv
// -----------------------------------------------------------------------------
// tb_sort4_drain
// Directed bench for sort4_drain. Expected elements go into a queue when a set
// is driven and are compared as the DUT transfers them.
// -----------------------------------------------------------------------------
module tb_sort4_drain;
  import sort4_pkg::*;

  typedef struct {
    elem_t      data;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  elem_t       r0, r1, r2, r3;
  logic        can_accept;
  logic        out_valid;
  logic        out_ready;
  elem_t       out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        overflow;
  logic        order_err;
  logic [15:0] sets_out;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          exp_sets = 0;
  bit          stall_seen = 1'b0;
  elem_t       hold_data;
  logic [1:0]  hold_idx;
  logic [3:0]  ready_pat = 4'b1001;
  int          n;

  sort4_drain #(.W(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .r0         (r0),
    .r1         (r1),
    .r2         (r2),
    .r3         (r3),
    .can_accept (can_accept),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .overflow   (overflow),
    .order_err  (order_err),
    .sets_out   (sets_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample just before the next edge, then advance to 1ns after it.
  task automatic cycle();
    exp_t e;
    if (!rst) begin
      if (stall_seen) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_data);
        check("stall_idx", out_idx, hold_idx);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("xfer_data", out_data, e.data);
          check("xfer_idx", out_idx, e.idx);
          check("xfer_last", out_last, e.last);
          if (e.last) exp_sets++;
        end
      end
      stall_seen = out_valid && !out_ready;
      hold_data  = out_data;
      hold_idx   = out_idx;
    end else begin
      stall_seen = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_set(input elem_t a, input elem_t b, input elem_t c,
                          input elem_t d, input bit accepted);
    exp_t e;
    r0 = a; r1 = b; r2 = c; r3 = d;
    done = 1'b1;
    if (accepted) begin
      e.data = a; e.idx = 2'd0; e.last = 1'b0; exp_q.push_back(e);
      e.data = b; e.idx = 2'd1; e.last = 1'b0; exp_q.push_back(e);
      e.data = c; e.idx = 2'd2; e.last = 1'b0; exp_q.push_back(e);
      e.data = d; e.idx = 2'd3; e.last = 1'b1; exp_q.push_back(e);
    end
    cycle();
    done = 1'b0;
  endtask

  task automatic drain(input bit stall_pat, input int limit, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < limit) begin
      out_ready = stall_pat ? ready_pat[cycles % 4] : 1'b1;
      cycle();
      cycles++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    exp_sets = 0;
    cycle();
    cycle();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_order_err", order_err, 0);
    check("rst_sets_out", sets_out, 0);
    check("rst_can_accept", can_accept, 1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; done = 1'b0; out_ready = 1'b0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;

    // Reset state.
    do_reset();

    // Basic set with out_ready high: one-cycle latency, four back-to-back beats.
    out_ready = 1'b1;
    send_set(8'd5, 8'd12, 8'd45, 8'd78, 1'b1);
    check("lat_valid_low", out_valid, 0);
    cycle();
    check("lat_valid_high", out_valid, 1);
    check("lat_first_data", out_data, 8'd5);
    drain(1'b0, 50, n);
    check("basic_cycles", n, 4);
    check("basic_idle", out_valid, 0);
    check("basic_sets_out", sets_out, exp_sets);
    check("basic_order_err", order_err, 0);

    // Stalling consumer, ready pattern 1,0,0,1.
    send_set(8'd15, 8'd30, 8'd60, 8'd90, 1'b1);
    drain(1'b1, 50, n);
    check("stall_sets_out", sets_out, exp_sets);

    // Three back-to-back sets into a stalled two-entry buffer: third dropped.
    out_ready = 1'b0;
    send_set(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    send_set(8'd6, 8'd7, 8'd8, 8'd9, 1'b1);
    check("full_can_accept", can_accept, 0);
    send_set(8'd11, 8'd12, 8'd13, 8'd14, 1'b0);
    check("drop_overflow", overflow, 1);
    check("drop_can_accept", can_accept, 0);
    drain(1'b0, 50, n);
    check("drop_no_bubble", n, 8);
    check("drop_sets_out", sets_out, exp_sets);
    check("drop_can_accept_after", can_accept, 1);

    // Full buffer with done landing on the idx 3 transfer: set accepted.
    do_reset();
    send_set(8'd20, 8'd21, 8'd22, 8'd23, 1'b1);
    send_set(8'd30, 8'd31, 8'd32, 8'd33, 1'b1);
    check("pp_full", can_accept, 0);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    check("pp_at_idx3", out_idx, 3);
    send_set(8'd40, 8'd41, 8'd42, 8'd43, 1'b1);
    check("pp_overflow", overflow, 0);
    check("pp_still_full", can_accept, 0);
    drain(1'b0, 50, n);
    check("pp_no_bubble", n, 8);
    check("pp_sets_out", sets_out, exp_sets);
    check("pp_overflow_end", overflow, 0);

    // Unsorted set flags order_err but is still emitted as given.
    send_set(8'd100, 8'd75, 8'd50, 8'd25, 1'b1);
    check("order_err_set", order_err, 1);
    drain(1'b0, 50, n);
    check("order_sets_out", sets_out, exp_sets);

    // Reset at idx 2 with a second set queued discards everything.
    out_ready = 1'b0;
    send_set(8'd1, 8'd1, 8'd2, 8'd2, 1'b1);
    send_set(8'd3, 8'd4, 8'd5, 8'd6, 1'b1);
    out_ready = 1'b1;
    cycle();
    cycle();
    check("mid_idx2", out_idx, 2);
    rst = 1'b1;
    out_ready = 1'b0;
    exp_q.delete();
    exp_sets = 0;
    cycle();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sets_out", sets_out, 0);
    check("mid_rst_can_accept", can_accept, 1);
    check("mid_rst_order_err", order_err, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("mid_rst_stays_idle", out_valid, 0);
    send_set(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
    drain(1'b0, 50, n);
    check("post_rst_cycles", n, 5);
    check("post_rst_sets_out", sets_out, exp_sets);
    check("post_rst_idle", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
